// File: rtl/beta.sv
// -----------------------------------------------------------------------------
// beta -- unpipelined single-cycle 6.004 Beta processor.
//
// Every rising clock edge retires one instruction: fetch, decode, register
// read, ALU / data-memory access and write-back all happen combinationally
// between edges. Instruction memory, data memory and the register file are
// internal submodules (instances im, dm, regfile) so a bench can preload them
// hierarchically.
//
// Parameters:
//   IMEM_WORDS  instruction memory depth in 32-bit words
//   DMEM_WORDS  data memory depth in 32-bit words
// Ports:
//   clk    system clock, all state updates on the rising edge
//   RESET  asynchronous active-high reset; forces PC to 0 and blocks all
//          register / memory writes while high (storage is not cleared)
// -----------------------------------------------------------------------------

// Instruction memory: combinational read. The write port is a spare program
// load path; the processor ties it off.
module beta_imem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] addr,
  output logic [31:0]   data
);
  logic [31:0] mem [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign data = mem[addr];
endmodule

// Data memory: one combinational read port and one synchronous write port
// sharing a single word address.
module beta_dmem #(
  parameter int WORDS = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) memory[addr] <= wdata;
  end

  assign rdata = memory[addr];
endmodule

// Register file: two combinational read ports, one write port. R31 always
// reads as zero and writes to it are dropped.
module beta_regfile (
  input  logic        clk,
  input  logic [4:0]  ra_addr,
  input  logic [4:0]  rb_addr,
  output logic [31:0] ra_data,
  output logic [31:0] rb_data,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] reg_file [0:31];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd31)) reg_file[wa] <= wd;
  end

  assign ra_data = (ra_addr == 5'd31) ? 32'd0 : reg_file[ra_addr];
  assign rb_data = (rb_addr == 5'd31) ? 32'd0 : reg_file[rb_addr];
endmodule

module beta #(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_WORDS = 256
) (
  input logic clk,
  input logic RESET
);
  localparam int IA = $clog2(IMEM_WORDS);
  localparam int DA = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  logic [31:0] PC;
  logic [31:0] pc_d;

  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [4:0]  rc, ra, rb;
  logic [31:0] lit_sext;

  logic [31:0] ra_data, rb_data;
  logic [4:0]  rb_sel;
  logic        rf_we, rf_we_gated;
  logic [31:0] rf_wd;

  logic        dm_we, dm_we_gated;
  logic [DA-1:0] dm_addr;
  logic [31:0] dm_rdata;

  logic [31:0] pc_inc, br_target, ea;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_valid;

  logic [31:0] abs_a, abs_b, div_q, div_result;
  logic        unused_bits;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  beta_imem #(.WORDS(IMEM_WORDS), .AW(IA)) im (
    .clk   (clk),
    .we    (1'b0),
    .waddr ({IA{1'b0}}),
    .wdata (32'd0),
    .addr  (PC[IA+1:2]),
    .data  (instr)
  );

  beta_regfile regfile (
    .clk     (clk),
    .ra_addr (ra),
    .rb_addr (rb_sel),
    .ra_data (ra_data),
    .rb_data (rb_data),
    .we      (rf_we_gated),
    .wa      (rc),
    .wd      (rf_wd)
  );

  beta_dmem #(.WORDS(DMEM_WORDS), .AW(DA)) dm (
    .clk   (clk),
    .we    (dm_we_gated),
    .addr  (dm_addr),
    .wdata (rb_data),
    .rdata (dm_rdata)
  );

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  assign opcode   = instr[31:26];
  assign rc       = instr[25:21];
  assign ra       = instr[20:16];
  assign rb       = instr[15:11];
  assign lit_sext = {{16{instr[15]}}, instr[15:0]};

  // ST needs the store data (Rc) on the second read port.
  assign rb_sel = (opcode == OP_ST) ? rc : rb;

  assign pc_inc    = PC + 32'd4;
  assign br_target = pc_inc + {lit_sext[29:0], 2'b00};
  assign ea        = ra_data + lit_sext;

  // Only the word-index bits of the effective address reach memory.
  assign unused_bits = ^{ea[31:DA+2], ea[1:0], br_target[1:0]};

  // ---------------------------------------------------------------------------
  // ALU: bit 4 of the opcode selects the sign-extended literal as operand B.
  // ---------------------------------------------------------------------------
  assign alu_a = ra_data;
  assign alu_b = opcode[4] ? lit_sext : rb_data;

  // Signed divide done on magnitudes so the most-negative / -1 case simply
  // wraps instead of overflowing; a zero divisor yields 0.
  assign abs_a      = alu_a[31] ? (32'd0 - alu_a) : alu_a;
  assign abs_b      = alu_b[31] ? (32'd0 - alu_b) : alu_b;
  assign div_q      = (abs_b == 32'd0) ? 32'd0 : (abs_a / abs_b);
  assign div_result = (alu_a[31] ^ alu_b[31]) ? (32'd0 - div_q) : div_q;

  always_comb begin
    alu_valid  = 1'b1;
    alu_result = 32'd0;
    case (opcode[3:0])
      4'h0: alu_result = alu_a + alu_b;
      4'h1: alu_result = alu_a - alu_b;
      4'h2: alu_result = alu_a * alu_b;
      4'h3: alu_result = div_result;
      4'h4: alu_result = {31'd0, alu_a == alu_b};
      4'h5: alu_result = {31'd0, $signed(alu_a) <  $signed(alu_b)};
      4'h6: alu_result = {31'd0, $signed(alu_a) <= $signed(alu_b)};
      4'h8: alu_result = alu_a & alu_b;
      4'h9: alu_result = alu_a | alu_b;
      4'hA: alu_result = alu_a ^ alu_b;
      4'hB: alu_result = ~(alu_a ^ alu_b);
      4'hC: alu_result = alu_a << alu_b[4:0];
      4'hD: alu_result = alu_a >> alu_b[4:0];
      4'hE: alu_result = $signed(alu_a) >>> alu_b[4:0];
      default: alu_valid = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control: next PC, write-back source, memory address. Anything not
  // recognised falls through as a NOP.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_d    = pc_inc;
    rf_we   = 1'b0;
    rf_wd   = alu_result;
    dm_we   = 1'b0;
    dm_addr = ea[DA+1:2];
    case (opcode)
      OP_LD: begin
        rf_we = 1'b1;
        rf_wd = dm_rdata;
      end
      OP_ST: begin
        dm_we = 1'b1;
      end
      OP_LDR: begin
        dm_addr = br_target[DA+1:2];
        rf_we   = 1'b1;
        rf_wd   = dm_rdata;
      end
      OP_JMP: begin
        rf_we = 1'b1;
        rf_wd = pc_inc;
        pc_d  = ra_data & ~32'd3;
      end
      OP_BEQ: begin
        rf_we = 1'b1;
        rf_wd = pc_inc;
        if (ra_data == 32'd0) pc_d = br_target;
      end
      OP_BNE: begin
        rf_we = 1'b1;
        rf_wd = pc_inc;
        if (ra_data != 32'd0) pc_d = br_target;
      end
      default: begin
        rf_we = opcode[5] & alu_valid;
      end
    endcase
  end

  // Storage has no reset of its own, so writes are blocked explicitly.
  assign rf_we_gated = rf_we & ~RESET;
  assign dm_we_gated = dm_we & ~RESET;

  always_ff @(posedge clk or posedge RESET) begin
    if (RESET) PC <= 32'd0;
    else       PC <= pc_d;
  end
endmodule

// File: tb/tb_beta.sv
// -----------------------------------------------------------------------------
// tb_beta -- self-checking bench for beta. A small instruction-level model of
// the Beta ISA steps alongside the DUT; PC, destination register and stored
// memory word are compared after every edge, plus directed constant checks.
// -----------------------------------------------------------------------------
module tb_beta;
  localparam int IW = 256;
  localparam int DW = 256;

  logic clk = 1'b0;
  logic RESET = 1'b1;

  beta #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
    .clk   (clk),
    .RESET (RESET)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int step_no = 0;

  logic [31:0] m_rf [32];
  logic [31:0] m_dm [DW];
  logic [31:0] m_im [IW];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [15:0] l);
    return {{16{l[15]}}, l};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] op, input int rc, input int ra, input int rb);
    return {op, 5'(rc), 5'(ra), 5'(rb), 11'd0};
  endfunction

  function automatic logic [31:0] enc_c(input logic [5:0] op, input int rc, input int ra, input logic [15:0] lit);
    return {op, 5'(rc), 5'(ra), lit};
  endfunction

  function automatic logic [31:0] rd(input int r);
    return (r == 31) ? 32'd0 : m_rf[r];
  endfunction

  function automatic int word_idx(input logic [31:0] byte_addr, input int depth);
    return int'(byte_addr / 32'd4) % depth;
  endfunction

  // Executes one instruction on the model; reports Rc and any stored word.
  task automatic model_step(output logic [31:0] ins, output int rc, output int midx);
    logic [5:0]  op;
    logic [31:0] a, b, c, res, next_pc, addr;
    logic        wr;
    longint      q;
    int          ra, rb;
    ins = m_im[word_idx(m_pc, IW)];
    op  = ins[31:26];
    rc  = int'(ins[25:21]);
    ra  = int'(ins[20:16]);
    rb  = int'(ins[15:11]);
    a   = rd(ra);
    b   = op[4] ? sx(ins[15:0]) : rd(rb);
    c   = rd(rc);
    next_pc = m_pc + 32'd4;
    res  = 32'd0;
    wr   = 1'b0;
    midx = -1;
    if (op >= 6'h20) begin
      wr = 1'b1;
      case (int'(op) % 16)
        0:  res = a + b;
        1:  res = a - b;
        2:  res = a * b;
        3:  begin
              if (b == 32'd0) res = 32'd0;
              else begin
                q = longint'(int'(a)) / longint'(int'(b));
                res = q[31:0];
              end
            end
        4:  res = (a == b) ? 32'd1 : 32'd0;
        5:  res = (int'(a) <  int'(b)) ? 32'd1 : 32'd0;
        6:  res = (int'(a) <= int'(b)) ? 32'd1 : 32'd0;
        8:  res = a & b;
        9:  res = a | b;
        10: res = a ^ b;
        11: res = ~(a ^ b);
        12: res = a << b[4:0];
        13: res = a >> b[4:0];
        14: res = 32'(int'(a) >>> b[4:0]);
        default: wr = 1'b0;
      endcase
    end else begin
      case (op)
        6'h18: begin res = m_dm[word_idx(a + sx(ins[15:0]), DW)]; wr = 1'b1; end
        6'h19: begin midx = word_idx(a + sx(ins[15:0]), DW); m_dm[midx] = c; end
        6'h1F: begin
                 addr = m_pc + 32'd4 + 32'd4 * sx(ins[15:0]);
                 res = m_dm[word_idx(addr, DW)];
                 wr = 1'b1;
               end
        6'h1B: begin res = m_pc + 32'd4; wr = 1'b1; next_pc = a & 32'hFFFF_FFFC; end
        6'h1C, 6'h1D: begin
                 res = m_pc + 32'd4;
                 wr = 1'b1;
                 if ((op == 6'h1C) == (a == 32'd0))
                   next_pc = m_pc + 32'd4 + 32'd4 * sx(ins[15:0]);
               end
        default: ;
      endcase
    end
    if (wr && rc != 31) m_rf[rc] = res;
    m_pc = next_pc;
  endtask

  // One retired instruction: advance model, clock DUT, compare.
  task automatic do_step();
    logic [31:0] ins;
    int rc, midx;
    model_step(ins, rc, midx);
    @(posedge clk);
    #1;
    step_no++;
    check($sformatf("pc_step%0d", step_no), dut.PC, m_pc);
    check($sformatf("r%0d_step%0d", rc, step_no), dut.regfile.reg_file[rc], m_rf[rc]);
    if (midx >= 0)
      check($sformatf("mem%0d_step%0d", midx, step_no), dut.dm.memory[midx], m_dm[midx]);
    $display("step %0d instr=%08h pc=%08h r%0d=%08h", step_no, ins, dut.PC, rc,
             dut.regfile.reg_file[rc]);
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_r%0d", tag, i), dut.regfile.reg_file[i], m_rf[i]);
    for (int i = 0; i < DW; i++)
      check($sformatf("%s_m%0d", tag, i), dut.dm.memory[i], m_dm[i]);
  endtask

  function automatic logic [31:0] rand_instr();
    int sel;
    logic [5:0] op;
    logic [15:0] lit;
    sel = $urandom_range(0, 9);
    lit = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 40)) - 16'd20 : 16'($urandom);
    case (sel)
      0, 1, 2: op = {2'b10, 4'($urandom_range(0, 15))};
      3, 4:    op = {2'b11, 4'($urandom_range(0, 15))};
      5:       op = 6'h18;
      6:       op = 6'h19;
      7:       begin op = 6'h1F; lit = 16'($urandom_range(0, 64)) - 16'd32; end
      8:       begin
                 op = ($urandom_range(0, 1) == 1) ? 6'h1C : 6'h1D;
                 lit = 16'($urandom_range(0, 12)) - 16'd6;
               end
      default: op = ($urandom_range(0, 2) == 0) ? 6'h1B : 6'($urandom_range(0, 23));
    endcase
    return {op, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), lit};
  endfunction

  initial begin
    // ---------------- preload during reset ----------------
    for (int i = 0; i < 32; i++) begin
      dut.regfile.reg_file[i] = 32'(i);
      m_rf[i] = 32'(i);
    end
    for (int i = 0; i < DW; i++) begin
      dut.dm.memory[i] = 32'(10 * i);
      m_dm[i] = 32'(10 * i);
    end
    for (int i = 0; i < IW; i++) m_im[i] = 32'd0;
    m_im[0]  = enc_c(6'h30, 1, 0, 16'd5);        // ADDC R0,5,R1
    m_im[1]  = enc_r(6'h20, 3, 1, 2);            // ADD R1,R2,R3
    m_im[2]  = enc_r(6'h20, 7, 31, 31);          // ADD R31,R31,R7
    m_im[3]  = enc_c(6'h18, 4, 31, 16'd8);       // LD R31,8,R4
    m_im[4]  = enc_c(6'h19, 4, 31, 16'd0);       // ST R4,0,R31
    m_im[5]  = enc_c(6'h30, 5, 31, 16'h0023);    // ADDC R31,0x23,R5
    m_im[6]  = enc_c(6'h1B, 6, 5, 16'd0);        // JMP R5,R6 -> 0x20
    m_im[7]  = enc_c(6'h30, 8, 31, 16'd99);      // skipped
    m_im[8]  = enc_c(6'h1C, 9, 1, 16'd5);        // BEQ R1 (nonzero) falls through
    m_im[9]  = enc_c(6'h33, 10, 1, 16'd0);       // DIVC R1,0,R10
    m_im[10] = enc_c(6'h07, 11, 1, 16'd1);       // undefined opcode
    m_im[11] = enc_c(6'h19, 31, 31, 16'd0);      // ST R31,0,R31
    m_im[12] = enc_c(6'h30, 12, 31, 16'd40);     // ADDC R31,40,R12
    m_im[13] = enc_r(6'h20, 13, 31, 31);         // ADD R31,R31,R13
    m_im[14] = enc_c(6'h31, 12, 12, 16'd4);      // loop: SUBC R12,4,R12
    m_im[15] = enc_c(6'h18, 14, 12, 16'd0);      // LD R12,0,R14
    m_im[16] = enc_r(6'h20, 13, 13, 14);         // ADD R13,R14,R13
    m_im[17] = enc_c(6'h1D, 31, 12, 16'hFFFC);   // BNE R12,loop
    m_im[18] = enc_c(6'h1C, 31, 31, 16'hFFFF);   // BEQ R31,-1 (halt)
    for (int i = 0; i < IW; i++) dut.im.mem[i] = m_im[i];
    m_pc = 32'd0;

    #5;
    check("pc_in_reset", dut.PC, 32'd0);
    @(negedge clk);
    check("pc_in_reset_after_edge", dut.PC, 32'd0);
    check("r1_no_write_in_reset", dut.regfile.reg_file[1], 32'd1);
    RESET = 1'b0;

    // ---------------- directed program ----------------
    do_step(); check("pc_first", dut.PC, 32'd4);
    do_step(); check("pc_second", dut.PC, 32'd8);
    check("addc_r1", dut.regfile.reg_file[1], 32'd5);
    check("add_r3", dut.regfile.reg_file[3], 32'd7);
    do_step(); check("r31_reads_zero", dut.regfile.reg_file[7], 32'd0);
    do_step(); check("ld_r4", dut.regfile.reg_file[4], 32'd20);
    do_step(); check("st_mem0", dut.dm.memory[0], 32'd20);
    do_step();
    do_step(); check("jmp_pc", dut.PC, 32'h20);
    check("jmp_link", dut.regfile.reg_file[6], 32'h1C);
    do_step(); check("beq_fallthrough", dut.PC, 32'h24);
    check("skipped_r8", dut.regfile.reg_file[8], 32'd8);
    do_step(); check("divc_zero", dut.regfile.reg_file[10], 32'd0);
    do_step(); check("undef_pc", dut.PC, 32'h2C);
    check("undef_no_write", dut.regfile.reg_file[11], 32'd11);
    for (int i = 0; i < 23; i++) do_step();       // into the middle of the loop

    // ---------------- reset mid-loop ----------------
    @(negedge clk);
    RESET = 1'b1;
    #1;
    check("pc_async_reset", dut.PC, 32'd0);
    check("r1_kept", dut.regfile.reg_file[1], 32'd5);
    check("r13_kept", dut.regfile.reg_file[13], m_rf[13]);
    check("mem9_kept", dut.dm.memory[9], 32'd90);
    dut.regfile.reg_file[1] = 32'd77;              // would be overwritten by ADDC if writes leaked
    m_rf[1] = 32'd77;
    @(posedge clk);
    #1;
    check("pc_held_reset", dut.PC, 32'd0);
    check("no_write_reset", dut.regfile.reg_file[1], 32'd77);
    @(negedge clk);
    RESET = 1'b0;
    m_pc = 32'd0;
    for (int i = 0; i < 58; i++) do_step();
    check("loop_sum", dut.regfile.reg_file[13], 32'd450);
    check("halt_pc", dut.PC, 32'h48);
    compare_all("directed");

    // ---------------- randomized program ----------------
    @(negedge clk);
    RESET = 1'b1;
    #1;
    check("pc_reset_rand", dut.PC, 32'd0);
    for (int i = 0; i < IW; i++) begin
      m_im[i] = rand_instr();
      dut.im.mem[i] = m_im[i];
    end
    for (int i = 0; i < 32; i++) begin
      m_rf[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 20)) - 32'd10 : 32'($urandom);
      dut.regfile.reg_file[i] = m_rf[i];
    end
    @(negedge clk);
    RESET = 1'b0;
    m_pc = 32'd0;
    for (int i = 0; i < 300; i++) do_step();
    compare_all("random");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
